// File: rtl/uart_pkg.sv
// Shared types for the UART receive path: parity mode, FSM states,
// per-frame status bundle and the data-length clamp helper.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE     = 2'b00,
    PAR_EVEN     = 2'b01,
    PAR_ODD      = 2'b10,
    PAR_NONE_ALT = 2'b11
  } parity_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2,
    ST_BRK_WAIT
  } rx_state_t;

  typedef struct packed {
    logic brk;
    logic frame_err;
    logic parity_err;
  } rx_status_t;

  localparam int STATUS_W = 3;
  localparam int MIN_LEN  = 5;

  // Out-of-range lengths are pulled into 5..max_w.
  function automatic logic [3:0] clamp_len(
    input logic [3:0]  len,
    input int unsigned max_w
  );
    if (32'(len) < MIN_LEN) return 4'(MIN_LEN);
    if (32'(len) > max_w) return 4'(max_w);
    return len;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports: clk, rst (sync, active high), push/din, pop, dout (head, 0 when empty), full, empty.
module uart_rx_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);

  // A push into a full FIFO is still taken when the head leaves
  // in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

  assign dout = empty ? '0 : mem[rptr[AW-1:0]];

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-FF sync, oversampled majority vote,
// frame FSM and FWFT output FIFO. Ports: rx in; data_len/parity_mode/
// two_stop config; m_data/m_status/m_valid/m_ready stream; overrun,
// clr_overrun, busy status.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int MAX_DATA_WIDTH = 9,
  parameter int SAMPLING_RATE  = 16,
  parameter int NUM_POLLS      = 5,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx,
  input  logic [3:0]                data_len,
  input  logic [1:0]                parity_mode,
  input  logic                      two_stop,
  output logic [MAX_DATA_WIDTH-1:0] m_data,
  output logic [STATUS_W-1:0]       m_status,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic                      overrun,
  input  logic                      clr_overrun,
  output logic                      busy
);

  localparam int CW    = $clog2(SAMPLING_RATE);
  localparam int MID   = SAMPLING_RATE / 2 - 1;
  localparam int FIRST = MID - NUM_POLLS / 2 +
                         ((NUM_POLLS % 2 == 0) ? 1 : 0);
  localparam int LAST  = FIRST + NUM_POLLS - 1;
  localparam int DEC   = LAST + 1;
  localparam int VW    = $clog2(NUM_POLLS + 1);
  localparam int MAJ   = NUM_POLLS / 2 + 1;
  localparam int EW    = MAX_DATA_WIDTH + STATUS_W;

  logic [1:0]                sync_q;
  logic                      sync_rx;
  rx_state_t                 state;
  rx_state_t                 state_nxt;
  logic [CW-1:0]             clk_cnt;
  logic [VW-1:0]             ones;
  logic [3:0]                idx;
  logic [3:0]                len_q;
  parity_mode_t              pmode_q;
  logic                      two_stop_q;
  logic [MAX_DATA_WIDTH-1:0] data_q;
  logic                      par_bit;
  logic                      par_err;
  logic                      frame_err;

  logic                      bit_end;
  logic                      dec;
  logic                      in_win;
  logic                      vote;
  logic                      par_en;
  logic                      exp_par;
  logic                      is_brk;
  logic                      commit;
  logic                      reject;
  logic                      brk;
  rx_status_t                status_c;
  logic [MAX_DATA_WIDTH-1:0] data_c;
  logic [EW-1:0]             fifo_dout;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      pop;

  assign sync_rx = sync_q[1];
  assign bit_end = (clk_cnt == CW'(SAMPLING_RATE - 1));
  assign dec     = (clk_cnt == CW'(DEC));
  assign in_win  = (clk_cnt >= CW'(FIRST)) &&
                   (clk_cnt <= CW'(LAST));
  assign vote    = (ones >= VW'(MAJ));
  assign par_en  = (pmode_q == PAR_EVEN) ||
                   (pmode_q == PAR_ODD);
  assign exp_par = (^data_q) ^ (pmode_q == PAR_ODD);
  // Line held low through data, parity and first stop bit.
  assign is_brk  = ~vote && (data_q == '0) &&
                   (~par_en || ~par_bit);

  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    reject    = 1'b0;
    brk       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!sync_rx) state_nxt = ST_START;
      end
      ST_START: begin
        if (dec && vote) begin
          state_nxt = ST_IDLE;
          reject    = 1'b1;
        end else if (bit_end) begin
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end && (idx == len_q - 4'd1))
          state_nxt = par_en ? ST_PARITY : ST_STOP1;
      end
      ST_PARITY: begin
        if (bit_end) state_nxt = ST_STOP1;
      end
      ST_STOP1: begin
        // Commit on the decision cycle so a start edge right
        // after the stop bit is still caught.
        if (dec && is_brk) begin
          commit    = 1'b1;
          brk       = 1'b1;
          state_nxt = ST_BRK_WAIT;
        end else if (dec && !two_stop_q) begin
          commit    = 1'b1;
          state_nxt = ST_IDLE;
        end else if (bit_end) begin
          state_nxt = ST_STOP2;
        end
      end
      ST_STOP2: begin
        if (dec) begin
          commit    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_BRK_WAIT: begin
        if (sync_rx) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    status_c.brk        = brk;
    status_c.frame_err  = brk | frame_err | ~vote;
    status_c.parity_err = ~brk & par_err;
    data_c              = brk ? '0 : data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= 2'b11;
      state      <= ST_IDLE;
      clk_cnt    <= '0;
      ones       <= '0;
      idx        <= '0;
      len_q      <= 4'(MIN_LEN);
      pmode_q    <= PAR_NONE;
      two_stop_q <= 1'b0;
      data_q     <= '0;
      par_bit    <= 1'b0;
      par_err    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], rx};
      state  <= state_nxt;
      if (state == ST_IDLE) begin
        clk_cnt <= '0;
        ones    <= '0;
        if (!sync_rx) begin
          len_q      <= clamp_len(data_len, MAX_DATA_WIDTH);
          pmode_q    <= parity_mode_t'(parity_mode);
          two_stop_q <= two_stop;
          data_q     <= '0;
          idx        <= '0;
          par_bit    <= 1'b0;
          par_err    <= 1'b0;
          frame_err  <= 1'b0;
        end
      end else begin
        clk_cnt <= bit_end ? '0 : clk_cnt + 1'b1;
        ones    <= bit_end ? '0 : ones + VW'(in_win & sync_rx);
      end
      if (state == ST_DATA && dec) data_q[idx] <= vote;
      if (state == ST_DATA && bit_end) idx <= idx + 4'd1;
      if (state == ST_PARITY && dec) begin
        par_bit <= vote;
        par_err <= (vote != exp_par);
      end
      if (state == ST_STOP1 && dec) frame_err <= ~vote;
    end
  end

  assign pop     = m_valid & m_ready;
  assign m_valid = ~fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (commit && fifo_full && !pop) begin
      overrun <= 1'b1;
    end else if (clr_overrun) begin
      overrun <= 1'b0;
    end
  end

  assign busy = (state != ST_IDLE) && (state != ST_BRK_WAIT) &&
                !commit && !reject;

  uart_rx_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (commit),
    .din   ({status_c, data_c}),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign {m_status, m_data} = fifo_dout;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: directed scenarios plus
// randomized frames checked against a frame-level reference model.
module tb_uart_rx_cfg;

  localparam int SR = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [3:0] data_len;
  logic [1:0] parity_mode;
  logic       two_stop;
  logic [8:0] m_data;
  logic [2:0] m_status;
  logic       m_valid;
  logic       m_ready;
  logic       overrun;
  logic       clr_overrun;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [11:0] got[$];
  logic [11:0] exp_q[$];

  uart_rx_cfg dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .data_len    (data_len),
    .parity_mode (parity_mode),
    .two_stop    (two_stop),
    .m_data      (m_data),
    .m_status    (m_status),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .overrun     (overrun),
    .clr_overrun (clr_overrun),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (!rst && m_valid && m_ready) got.push_back({m_status, m_data});

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int eff_len(input int len);
    return (len < 5) ? 5 : ((len > 9) ? 9 : len);
  endfunction

  function automatic bit good_par(input logic [8:0] m,
                                  input logic [1:0] pm);
    return bit'(($countones(m) % 2) == 1) ^ (pm == 2'b10);
  endfunction

  // Expected {status, data} for one frame as seen on the wire.
  function automatic logic [11:0] model(
    input logic [8:0] d, input int len, input logic [1:0] pm,
    input bit pbit, input bit s1, input bit s2, input bit ts);
    int         l;
    logic [8:0] m;
    bit         pen;
    bit         perr;
    bit         ferr;
    l    = eff_len(len);
    m    = d & 9'((1 << l) - 1);
    pen  = (pm == 2'b01) || (pm == 2'b10);
    if (m == 0 && (!pen || !pbit) && !s1) return {3'b110, 9'h0};
    perr = pen && (pbit != good_par(m, pm));
    ferr = !s1 || (ts && !s2);
    return {1'b0, ferr, perr, m};
  endfunction

  task automatic bit_out(input bit b);
    rx = b;
    repeat (SR) @(negedge clk);
  endtask

  task automatic send_frame(
    input logic [8:0] d, input int len, input logic [1:0] pm,
    input bit ts, input bit bad, input bit s1, input bit s2,
    input bit expect_push);
    int         l;
    logic [8:0] m;
    bit         pen;
    bit         pbit;
    l    = eff_len(len);
    m    = d & 9'((1 << l) - 1);
    pen  = (pm == 2'b01) || (pm == 2'b10);
    pbit = good_par(m, pm) ^ bad;
    data_len    = 4'(len);
    parity_mode = pm;
    two_stop    = ts;
    bit_out(1'b0);
    // Config changes mid-frame must not affect this frame.
    data_len    = 4'($urandom);
    parity_mode = 2'($urandom);
    two_stop    = 1'($urandom);
    for (int i = 0; i < l; i++) bit_out(d[i]);
    if (pen) bit_out(pbit);
    bit_out(s1);
    if (ts) bit_out(s2);
    if (expect_push)
      exp_q.push_back(model(d, len, pm, pbit, s1, s2, ts));
    rx = 1'b1;
    repeat (2 * SR) @(negedge clk);
  endtask

  task automatic check_q(input string tag);
    int n;
    repeat (4) @(negedge clk);
    chk({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_entry%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    bit seen;
    rst = 1'b1;
    rx = 1'b1;
    data_len = 4'd8;
    parity_mode = 2'b00;
    two_stop = 1'b0;
    m_ready = 1'b1;
    clr_overrun = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_data", 32'(m_data), 0);
    chk("rst_status", 32'(m_status), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_busy", 32'(busy), 0);
    repeat (SR) @(negedge clk);

    // 8N1 0xA5
    send_frame(9'h0A5, 8, 2'b00, 0, 0, 1, 1, 1);
    check_q("t1_8n1");
    chk("t1_overrun", 32'(overrun), 0);

    // 7E2 bad parity, then 7O1 good parity
    send_frame(9'h055, 7, 2'b01, 1, 1, 1, 1, 1);
    send_frame(9'h055, 7, 2'b10, 0, 0, 1, 1, 1);
    check_q("t2_parity");

    // 9-bit 0x1FF with stop bit low
    send_frame(9'h1FF, 9, 2'b00, 0, 0, 0, 1, 1);
    check_q("t3_stop_low");

    // Break: 20 bit times low with 8E1 config
    data_len = 4'd8;
    parity_mode = 2'b01;
    two_stop = 1'b0;
    rx = 1'b0;
    repeat (20 * SR) @(negedge clk);
    exp_q.push_back(model(9'h0, 8, 2'b01, 0, 0, 0, 0));
    chk("t4_brk_busy", 32'(busy), 0);
    rx = 1'b1;
    repeat (2 * SR) @(negedge clk);
    check_q("t4_break");
    send_frame(9'h03C, 8, 2'b01, 0, 0, 1, 1, 1);
    check_q("t4_after_break");

    // Glitch of 4 clocks
    @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    seen = 0;
    for (int i = 0; i < 3 * SR; i++) begin
      @(negedge clk);
      if (busy) seen = 1;
    end
    chk("t5_glitch_busy", 32'(seen), 1);
    chk("t5_glitch_busy_end", 32'(busy), 0);
    check_q("t5_glitch");

    // Overrun
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send_frame(9'($urandom), 8, 2'b00, 0, 0, 1, 1, 1);
    chk("t5_ovr_before", 32'(overrun), 0);
    chk("t5_ovr_valid", 32'(m_valid), 1);
    send_frame(9'($urandom), 8, 2'b00, 0, 0, 1, 1, 0);
    chk("t5_ovr_set", 32'(overrun), 1);
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    chk("t5_ovr_clr", 32'(overrun), 0);
    m_ready = 1'b1;
    repeat (8) @(negedge clk);
    check_q("t5_ovr");

    // Reset mid-DATA with two entries queued
    m_ready = 1'b0;
    send_frame(9'h011, 8, 2'b00, 0, 0, 1, 1, 1);
    send_frame(9'h022, 8, 2'b00, 0, 0, 1, 1, 1);
    chk("t6_queued", 32'(m_valid), 1);
    data_len = 4'd8;
    parity_mode = 2'b00;
    bit_out(1'b0);
    bit_out(1'b1);
    bit_out(1'b0);
    bit_out(1'b1);
    chk("t6_busy_mid", 32'(busy), 1);
    rst = 1'b1;
    rx = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_rst_valid", 32'(m_valid), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    exp_q.delete();
    repeat (SR) @(negedge clk);
    m_ready = 1'b1;
    send_frame(9'h081, 8, 2'b00, 0, 0, 1, 1, 1);
    check_q("t6_after_rst");

    // Randomized frames
    for (int n = 0; n < 24; n++) begin
      logic [1:0] pm;
      bit         pen;
      pm  = 2'($urandom_range(0, 3));
      pen = (pm == 2'b01) || (pm == 2'b10);
      send_frame(9'($urandom), int'($urandom_range(3, 12)), pm,
                 1'($urandom), pen ? 1'($urandom) : 1'b0,
                 ($urandom % 5) != 0, ($urandom % 5) != 0, 1);
      if (n % 6 == 5) check_q($sformatf("rnd%0d", n));
    end
    check_q("rnd_end");
    chk("rnd_overrun", 32'(overrun), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
